// File: rtl/dco_nco_if.sv
// Control-word channel between the loop filter and the DCO.
// A word moves on a rising clk_ref edge where ctrl_valid and ctrl_ready are both 1; the source holds word and sync_update stable until then.
interface dco_nco_if #(
   parameter int CTRL_W = 13
);
   logic [CTRL_W-1:0] ctrl_word;
   logic              ctrl_valid;
   logic              ctrl_ready;
   logic              sync_update;

   modport master (
      output ctrl_word,
      output ctrl_valid,
      output sync_update,
      input  ctrl_ready
   );

   modport slave (
      input  ctrl_word,
      input  ctrl_valid,
      input  sync_update,
      output ctrl_ready
   );
endinterface

// File: rtl/dco_nco.sv
// Digitally-controlled oscillator: maps a sign-magnitude tuning word to a clamped FCW
// that drives a phase accumulator; updates apply immediately or at the next wrap.
module dco_nco #(
   parameter int               CTRL_W     = 13,
   parameter int               ACC_W      = 24,
   parameter int               PHASE_W    = 8,
   parameter int               GAIN_SHIFT = 8,
   parameter logic [ACC_W-1:0] FCW_CENTER = 24'h080000,
   parameter logic [ACC_W-1:0] FCW_MIN    = 24'h000100,
   parameter logic [ACC_W-1:0] FCW_MAX    = 24'h100000
) (
   input  logic               clk_ref,
   input  logic               rst,
   input  logic               en,
   dco_nco_if.slave           ctrl,
   output logic               clk_dco,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap,
   output logic [ACC_W-1:0]   fcw_active,
   output logic               sat,
   output logic [1:0]         fsm_state
);
   typedef enum logic [1:0] {IDLE, MAP, APPLY, WAIT_WRAP} state_t;

   // Two guard bits keep the signed sum exact for any magnitude before clamping.
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] CENTER_S = $signed({2'b00, FCW_CENTER});
   localparam logic signed [SW-1:0] MIN_S    = $signed({2'b00, FCW_MIN});
   localparam logic signed [SW-1:0] MAX_S    = $signed({2'b00, FCW_MAX});

   state_t            state, state_nxt;
   logic [CTRL_W-1:0] word_q;
   logic              sync_q;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  fcw_target;
   logic [ACC_W:0]    acc_sum;
   logic              carry;
   logic              ready;
   logic              accept;
   logic              load_target;
   logic              apply;
   logic [SW-1:0]     mag_ext;
   logic signed [SW-1:0] delta;
   logic signed [SW-1:0] sum;
   logic [ACC_W-1:0]  fcw_mapped;
   logic              sat_mapped;

   assign acc_sum         = {1'b0, acc} + {1'b0, fcw_active};
   assign carry           = acc_sum[ACC_W];
   assign ctrl.ctrl_ready = ready;
   assign clk_dco         = acc[ACC_W-1];
   assign phase           = acc[ACC_W-1 -: PHASE_W];
   assign fsm_state       = state;

   always_comb begin
      mag_ext    = SW'(word_q[CTRL_W-1:1]);
      delta      = $signed(mag_ext << GAIN_SHIFT);
      sum        = word_q[0] ? (CENTER_S + delta) : (CENTER_S - delta);
      fcw_mapped = sum[ACC_W-1:0];
      sat_mapped = 1'b0;
      if (sum < MIN_S) begin
         fcw_mapped = FCW_MIN;
         sat_mapped = 1'b1;
      end else if (sum > MAX_S) begin
         fcw_mapped = FCW_MAX;
         sat_mapped = 1'b1;
      end
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ready       = 1'b0;
      accept      = 1'b0;
      load_target = 1'b0;
      apply       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (ctrl.ctrl_valid) begin
               accept    = 1'b1;
               state_nxt = MAP;
            end
         end
         MAP: begin
            load_target = 1'b1;
            state_nxt   = sync_q ? WAIT_WRAP : APPLY;
         end
         APPLY: begin
            apply     = 1'b1;
            state_nxt = IDLE;
         end
         WAIT_WRAP: begin
            // A frozen accumulator has no phase to protect, so apply at once.
            if (!en || carry) begin
               apply     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         wrap       <= 1'b0;
         word_q     <= '0;
         sync_q     <= 1'b0;
         fcw_target <= FCW_CENTER;
         fcw_active <= FCW_CENTER;
         sat        <= 1'b0;
      end else begin
         if (en) acc <= acc_sum[ACC_W-1:0];
         wrap <= en & carry;
         if (accept) begin
            word_q <= ctrl.ctrl_word;
            sync_q <= ctrl.sync_update;
         end
         if (load_target) begin
            fcw_target <= fcw_mapped;
            sat        <= sat_mapped;
         end
         if (apply) fcw_active <= fcw_target;
      end
   end
endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco: free-run waveform, FCW mapping and clamps,
// wrap-synchronous updates, en=0 while pending, and reset during a pending update.
module tb_dco_nco;
   logic        clk_ref = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        clk_dco;
   logic [7:0]  phase;
   logic        wrap;
   logic [23:0] fcw_active;
   logic        sat;
   logic [1:0]  fsm_state;
   int          n_vec = 0;
   int          n_bad = 0;

   dco_nco_if #(.CTRL_W(13)) ctrl_if ();

   dco_nco dut (
      .clk_ref    (clk_ref),
      .rst        (rst),
      .en         (en),
      .ctrl       (ctrl_if),
      .clk_dco    (clk_dco),
      .phase      (phase),
      .wrap       (wrap),
      .fcw_active (fcw_active),
      .sat        (sat),
      .fsm_state  (fsm_state)
   );

   always #5 clk_ref = ~clk_ref;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_ref);
      #1;
   endtask

   // Immediate update: word accepted at edge N, FCW visible after N+2, ready back for N+3.
   task automatic apply_imm(input logic [12:0] w, input logic [23:0] prev_fcw,
                            input logic [23:0] exp_fcw, input logic exp_sat);
      int waited = 0;
      while (!ctrl_if.ctrl_ready && waited < 50) begin
         tick();
         waited++;
      end
      check("ready_before_send", 32'(ctrl_if.ctrl_ready), 32'd1);
      ctrl_if.ctrl_word   = w;
      ctrl_if.sync_update = 1'b0;
      ctrl_if.ctrl_valid  = 1'b1;
      tick();
      ctrl_if.ctrl_valid = 1'b0;
      check("ready_n", 32'(ctrl_if.ctrl_ready), 32'd0);
      tick();
      check("ready_n1", 32'(ctrl_if.ctrl_ready), 32'd0);
      check("fcw_hold_n1", 32'(fcw_active), 32'(prev_fcw));
      tick();
      check("fcw_n2", 32'(fcw_active), 32'(exp_fcw));
      check("sat_n2", 32'(sat), 32'(exp_sat));
      check("ready_n2", 32'(ctrl_if.ctrl_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_if.ctrl_valid  = 1'b0;
      ctrl_if.ctrl_word   = '0;
      ctrl_if.sync_update = 1'b0;

      // Reset values
      #2 rst = 1'b1;
      #1;
      check("rst_fcw", 32'(fcw_active), 32'h080000);
      check("rst_clk", 32'(clk_dco), 32'd0);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      check("rst_ready", 32'(ctrl_if.ctrl_ready), 32'd1);
      check("rst_state", 32'(fsm_state), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      en  = 1'b1;

      // Free run at FCW_CENTER: 8 phase LSBs per cycle, 32-cycle period
      for (int k = 1; k <= 64; k++) begin
         tick();
         check("free_phase", 32'(phase), 32'((k * 8) % 256));
         check("free_clk", 32'(clk_dco), 32'((k % 32) >= 16));
         check("free_wrap", 32'(wrap), 32'((k % 32) == 0));
      end
      check("free_sat", 32'(sat), 32'd0);

      // Mapping and clamp boundaries
      apply_imm({12'd1, 1'b1},    24'h080000, 24'h080100, 1'b0);
      apply_imm({12'd4095, 1'b0}, 24'h080100, 24'h000100, 1'b1);
      apply_imm({12'd2048, 1'b1}, 24'h000100, 24'h100000, 1'b0);
      apply_imm({12'd2049, 1'b1}, 24'h100000, 24'h100000, 1'b1);
      apply_imm({12'd0, 1'b0},    24'h100000, 24'h080000, 1'b0);
      apply_imm({12'd100, 1'b0},  24'h080000, 24'h079C00, 1'b0);
      apply_imm({12'd0, 1'b1},    24'h079C00, 24'h080000, 1'b0);

      // Restart from a known phase for the wrap-synchronous tests
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         if (k == 11) begin
            ctrl_if.ctrl_word   = {12'd1024, 1'b1};
            ctrl_if.sync_update = 1'b1;
            ctrl_if.ctrl_valid  = 1'b1;
         end
         if (k == 12) ctrl_if.ctrl_valid = 1'b0;
         if (k == 14) begin
            ctrl_if.ctrl_word   = {12'd0, 1'b0};
            ctrl_if.sync_update = 1'b0;
            ctrl_if.ctrl_valid  = 1'b1;
         end
         if (k == 32) ctrl_if.ctrl_valid = 1'b0;
         tick();
         if (k <= 31) begin
            check("sync_phase", 32'(phase), 32'(k * 8));
            check("sync_clk", 32'(clk_dco), 32'(k >= 16));
            check("sync_wrap", 32'(wrap), 32'd0);
            check("sync_fcw_hold", 32'(fcw_active), 32'h080000);
         end
         if (k >= 11 && k <= 31) check("sync_ready_low", 32'(ctrl_if.ctrl_ready), 32'd0);
         if (k == 32) begin
            check("sync_wrap_edge", 32'(wrap), 32'd1);
            check("sync_fcw_new", 32'(fcw_active), 32'h0C0000);
            check("sync_phase_wrap", 32'(phase), 32'd0);
            check("sync_ready_back", 32'(ctrl_if.ctrl_ready), 32'd1);
         end
         if (k == 33) begin
            check("sync_phase_33", 32'(phase), 32'h0C);
            check("sync_fcw_33", 32'(fcw_active), 32'h0C0000);
            check("sync_wrap_33", 32'(wrap), 32'd0);
         end
         if (k == 34) check("sync_phase_34", 32'(phase), 32'h18);
      end

      // Pending wrap-synchronous update released by en=0
      ctrl_if.ctrl_word   = {12'd512, 1'b1};
      ctrl_if.sync_update = 1'b1;
      ctrl_if.ctrl_valid  = 1'b1;
      tick();
      ctrl_if.ctrl_valid = 1'b0;
      check("en0_phase_35", 32'(phase), 32'h24);
      check("en0_ready_35", 32'(ctrl_if.ctrl_ready), 32'd0);
      tick();
      check("en0_phase_36", 32'(phase), 32'h30);
      check("en0_fcw_36", 32'(fcw_active), 32'h0C0000);
      check("en0_ready_36", 32'(ctrl_if.ctrl_ready), 32'd0);
      en = 1'b0;
      tick();
      check("en0_fcw_37", 32'(fcw_active), 32'h0A0000);
      check("en0_phase_37", 32'(phase), 32'h30);
      check("en0_wrap_37", 32'(wrap), 32'd0);
      check("en0_ready_37", 32'(ctrl_if.ctrl_ready), 32'd1);
      tick();
      check("en0_phase_38", 32'(phase), 32'h30);
      check("en0_wrap_38", 32'(wrap), 32'd0);
      en = 1'b1;
      tick();
      check("en1_phase_39", 32'(phase), 32'h3A);

      // Reset while a wrap-synchronous target of 0x0C0000 is pending
      ctrl_if.ctrl_word   = {12'd1024, 1'b1};
      ctrl_if.sync_update = 1'b1;
      ctrl_if.ctrl_valid  = 1'b1;
      tick();
      ctrl_if.ctrl_valid = 1'b0;
      repeat (6) tick();
      check("pend_phase", 32'(phase), 32'h80);
      check("pend_clk", 32'(clk_dco), 32'd1);
      check("pend_ready", 32'(ctrl_if.ctrl_ready), 32'd0);
      check("pend_fcw", 32'(fcw_active), 32'h0A0000);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_fcw", 32'(fcw_active), 32'h080000);
      check("mid_rst_clk", 32'(clk_dco), 32'd0);
      check("mid_rst_phase", 32'(phase), 32'd0);
      check("mid_rst_wrap", 32'(wrap), 32'd0);
      check("mid_rst_ready", 32'(ctrl_if.ctrl_ready), 32'd1);
      check("mid_rst_state", 32'(fsm_state), 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         check("post_rst_fcw", 32'(fcw_active), 32'h080000);
         check("post_rst_ready", 32'(ctrl_if.ctrl_ready), 32'd1);
         check("post_rst_phase", 32'(phase), 32'((k * 8) % 256));
         check("post_rst_wrap", 32'(wrap), 32'((k % 32) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
- Synthesisable, parametrised digitally-controlled oscillator that replaces the behavioural VCO model in the DPLL loop.
- A sign-magnitude control word from the loop filter is mapped to a frequency control word (FCW), then clamped. The clamped FCW drives a phase accumulator clocked by the reference clock.
- Provides a square-wave output, phase word, wrap pulse, and a phase-continuous (wrap-synchronous) update mode, which the old model did not have.

Parameters:
- CTRL_W, 13, control word width; bit 0 = sign (1 = add, 0 = subtract), bits [CTRL_W-1:1] = magnitude.
- ACC_W, 24, phase accumulator and FCW width.
- PHASE_W, 8, width of phase output (top accumulator bits); PHASE_W <= ACC_W.
- GAIN_SHIFT, 8, left shift applied to magnitude (DCO gain).
- FCW_CENTER, 24'h080000, free-running FCW (Fo).
- FCW_MIN, 24'h000100, lower clamp.
- FCW_MAX, 24'h100000, upper clamp.

Ports:
- clk_ref  in  1  reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator enable.
- ctrl_word  in  CTRL_W  sign-magnitude tuning word.
- ctrl_valid  in  1  ctrl_word valid.
- ctrl_ready  out  1  block can accept a new word.
- sync_update  in  1  sampled with ctrl_word: 1 = apply at next wrap, 0 = apply immediately.
- clk_dco  out  1  oscillator output = acc[ACC_W-1].
- phase  out  PHASE_W  acc[ACC_W-1 -: PHASE_W].
- wrap  out  1  one-cycle pulse, registered carry-out of the accumulator add.
- fcw_active  out  ACC_W  FCW currently driving the accumulator.
- sat  out  1  last accepted word was clamped.

Behaviour:
- Reset (async assert, sync release):
  - acc=0, clk_dco=0, phase=0, wrap=0, sat=0.
  - fcw_active=fcw_target=FCW_CENTER.
  - ctrl_ready=1; state IDLE; any pending update discarded.
- Accept: ctrl_valid & ctrl_ready at edge N. Latch ctrl_word and sync_update. ctrl_valid while ctrl_ready=0 is ignored; the source holds the word.
- Map (cycle N+1, registered into fcw_target and sat):
  - delta = mag << GAIN_SHIFT, computed in ACC_W+2 signed bits.
  - sum = FCW_CENTER + delta if sign=1, else FCW_CENTER - delta.
  - sum < FCW_MIN -> FCW_MIN, sat=1; sum > FCW_MAX -> FCW_MAX, sat=1; otherwise sum, sat=0. Equality with a bound is not saturation.
  - mag=0 -> FCW_CENTER for either sign.
- States:
  - IDLE: ready=1; accept -> MAP.
  - MAP: ready=0; go to APPLY if the latched sync_update=0, else to WAIT_WRAP.
  - APPLY: fcw_active <= fcw_target -> IDLE. fcw_active is visible at N+2; ctrl_ready=1 again at N+3.
  - WAIT_WRAP: ready=0. In the cycle the accumulator add carries out (the same edge that sets wrap=1), fcw_active <= fcw_target -> IDLE. The next add uses the new FCW.
  - en=0 in WAIT_WRAP: apply on the next edge (no phase continuity to protect) -> IDLE.
- Accumulator:
  - en=1: acc <= acc + fcw_active mod 2^ACC_W; wrap <= carry.
  - en=0: acc holds, wrap=0, clk_dco and phase hold.
- Output frequency = f_clk_ref * fcw_active / 2^ACC_W.
- clk_dco and phase are registered (from acc); no combinational path from inputs to outputs.
- Reset mid-operation (any state): returns to the reset values above; pending target lost.

Test Plan:
- Reset, en=1, defaults -> fcw_active=0x080000; clk_dco period 32 clk_ref cycles (16 high/16 low); wrap pulses every 32 cycles; sat=0.
- ctrl_word={12'd1,1'b1}, sync_update=0, accepted at N -> fcw_active=0x080100 at N+2, sat=0, ctrl_ready low N+1..N+2, high N+3.
- ctrl_word={12'd4095,1'b0} -> fcw_active=0x000100, sat=1. Then {12'd2048,1'b1} -> 0x100000, sat=0 (boundary). Then {12'd2049,1'b1} -> 0x100000, sat=1. Then {12'd0,1'b0} -> 0x080000, sat=0.
- sync_update=1 accepted mid-period -> fcw_active unchanged until the cycle wrap=1; ctrl_ready stays 0 until then; phase continuous, no glitch on clk_dco. A second ctrl_valid during the wait is not accepted.
- sync_update=1 pending, then en=0 -> fcw_active updated next edge, acc frozen, wrap=0, ctrl_ready=1 the following cycle.
- rst asserted while in WAIT_WRAP with target 0x0C0000 -> outputs immediately at reset values (fcw_active=0x080000, clk_dco=0, wrap=0, ctrl_ready=1); the target is never applied after release.
